// File: rtl/control_pkg.sv
// Shared decode definitions for the ID stage.
// Contents: the control word (ctrl_t) that execute consumes, ALU and operand-select
// encodings, the BUBBLE and INVALID control words, the RV32I opcode/funct
// constants for the supported subset, and the decode FSM state type.
package control;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SLT  = 4'd1;
    localparam logic [3:0] ALU_SLTU = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;

    localparam logic       A_RS1 = 1'b0;
    localparam logic       A_PC  = 1'b1;

    localparam logic [2:0] IMM_I  = 3'd0;
    localparam logic [2:0] IMM_S  = 3'd1;
    localparam logic [2:0] IMM_U  = 3'd2;
    localparam logic [2:0] IMM_SH = 3'd3;

    typedef struct packed {
        logic       bubble;
        logic       invalid;
        logic       jump;
        logic       load;
        logic       store;
        logic       reg_write;
        logic [3:0] alu_op;
        logic       a_sel;
        logic [2:0] imm_sel;
    } ctrl_t;

    // A bubble enables nothing, so operation and selects are don't-care.
    localparam ctrl_t BUBBLE = '{bubble: 1'b1, invalid: 1'b0, jump: 1'b0,
                                 load: 1'b0, store: 1'b0, reg_write: 1'b0,
                                 alu_op: 4'bxxxx, a_sel: 1'bx, imm_sel: 3'bxxx};

    // jump=1 makes execute redirect to the trap vector and raise flush.
    localparam ctrl_t INVALID = '{bubble: 1'b0, invalid: 1'b1, jump: 1'b1,
                                  load: 1'b0, store: 1'b0, reg_write: 1'b0,
                                  alu_op: ALU_ADD, a_sel: A_RS1, imm_sel: IMM_I};

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_W    = 3'b010;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic {RUN, TRAP} decode_state_t;

endpackage

// File: rtl/inst_decoder.sv
// Combinational RV32I-subset decoder.
// Ports:
//   inst     in  32      instruction word
//   ctrl     out ctrl_t  control word (INVALID for anything unsupported)
//   uses_rs1 out 1       instruction reads rs1
//   uses_rs2 out 1       instruction reads rs2
module inst_decoder
    import control::*;
(
    input  logic [31:0] inst,
    output ctrl_t       ctrl,
    output logic        uses_rs1,
    output logic        uses_rs2
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    // Register and immediate fields do not affect classification.
    assign unused_fields = ^{inst[24:15], inst[11:7]};

    always_comb begin
        ctrl = INVALID;
        // Every matched opcode already ends in 2'b11; the explicit test keeps
        // compressed encodings out even if the opcode table grows.
        if (inst[1:0] == 2'b11) begin
            case (opcode)
                OPC_OP_IMM: begin
                    ctrl = '{bubble: 1'b0, invalid: 1'b0, jump: 1'b0,
                             load: 1'b0, store: 1'b0, reg_write: 1'b1,
                             alu_op: ALU_ADD, a_sel: A_RS1, imm_sel: IMM_I};
                    case (funct3)
                        F3_ADD:  ctrl.alu_op = ALU_ADD;
                        F3_SLT:  ctrl.alu_op = ALU_SLT;
                        F3_SLTU: ctrl.alu_op = ALU_SLTU;
                        F3_AND:  ctrl.alu_op = ALU_AND;
                        F3_OR:   ctrl.alu_op = ALU_OR;
                        F3_XOR:  ctrl.alu_op = ALU_XOR;
                        F3_SLL: begin
                            if (funct7 == F7_ZERO) begin
                                ctrl.alu_op  = ALU_SLL;
                                ctrl.imm_sel = IMM_SH;
                            end else begin
                                ctrl = INVALID;
                            end
                        end
                        default: begin  // F3_SR
                            ctrl.imm_sel = IMM_SH;
                            if (funct7 == F7_ZERO)
                                ctrl.alu_op = ALU_SRL;
                            else if (funct7 == F7_ALT)
                                ctrl.alu_op = ALU_SRA;
                            else
                                ctrl = INVALID;
                        end
                    endcase
                end
                OPC_AUIPC: begin
                    ctrl = '{bubble: 1'b0, invalid: 1'b0, jump: 1'b0,
                             load: 1'b0, store: 1'b0, reg_write: 1'b1,
                             alu_op: ALU_ADD, a_sel: A_PC, imm_sel: IMM_U};
                end
                OPC_LOAD: begin
                    if (funct3 == F3_W)
                        ctrl = '{bubble: 1'b0, invalid: 1'b0, jump: 1'b0,
                                 load: 1'b1, store: 1'b0, reg_write: 1'b1,
                                 alu_op: ALU_ADD, a_sel: A_RS1, imm_sel: IMM_I};
                end
                OPC_STORE: begin
                    if (funct3 == F3_W)
                        ctrl = '{bubble: 1'b0, invalid: 1'b0, jump: 1'b0,
                                 load: 1'b0, store: 1'b1, reg_write: 1'b0,
                                 alu_op: ALU_ADD, a_sel: A_RS1, imm_sel: IMM_S};
                end
                default: ctrl = INVALID;
            endcase
        end
    end

    assign uses_rs1 = !ctrl.invalid && (opcode != OPC_AUIPC);
    assign uses_rs2 = ctrl.store;

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode stage: decodes the fetch word and registers the control
// word, PC, instruction and register indices into the ID/EX boundary. Inserts
// load-use bubbles and parks in TRAP after an invalid instruction until flush.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   if_valid/inst/pc      fetch word;  if_ready: word consumed this cycle
//   ex_ready              execute accepts the ID/EX register
//   flush                 redirect from execute, kills the fetch word
//   id_ctrl/pc/inst       registered control word, PC, instruction
//   id_rs1/rs2/rd         registered register indices
module decode_stage
    import control::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [31:0]     if_inst,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_ready,
    input  logic            ex_ready,
    input  logic            flush,
    output ctrl_t           id_ctrl,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_inst,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [4:0]      id_rd
);

    typedef enum logic [1:0] {LD_HOLD, LD_BUBBLE, LD_DECODE} load_sel_t;

    ctrl_t         dec_ctrl;
    logic          uses_rs1;
    logic          uses_rs2;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [4:0]    rd;
    logic          adv;
    logic          hz;
    decode_state_t state;
    decode_state_t state_next;
    load_sel_t     load_sel;

    inst_decoder u_dec (
        .inst     (if_inst),
        .ctrl     (dec_ctrl),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2)
    );

    assign rs1 = if_inst[19:15];
    assign rs2 = if_inst[24:20];
    assign rd  = if_inst[11:7];
    assign adv = ex_ready | flush;

    // A load in ID/EX cannot forward to the word behind it; x0 never hazards.
    assign hz = id_ctrl.load && (id_rd != 5'd0) && if_valid &&
                ((uses_rs1 && (rs1 == id_rd)) || (uses_rs2 && (rs2 == id_rd)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= RUN;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (adv) begin
            if (flush)
                state_next = RUN;
            else if (state == RUN && if_valid && !hz && dec_ctrl.invalid)
                state_next = TRAP;
        end
    end

    // Flush outranks stall, hazard and TRAP. While trapped, wrong-path words
    // are drained (consumed) but only bubbles enter ID/EX.
    always_comb begin
        if_ready = 1'b0;
        load_sel = LD_HOLD;
        if (adv) begin
            if (flush || state == TRAP || !if_valid) begin
                if_ready = 1'b1;
                load_sel = LD_BUBBLE;
            end else if (hz) begin
                load_sel = LD_BUBBLE;
            end else begin
                if_ready = 1'b1;
                load_sel = LD_DECODE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ctrl <= BUBBLE;
            id_pc   <= '0;
            id_inst <= NOP_INST;
            id_rs1  <= 5'd0;
            id_rs2  <= 5'd0;
            id_rd   <= 5'd0;
        end else begin
            case (load_sel)
                LD_BUBBLE: begin
                    // id_pc deliberately keeps its last value.
                    id_ctrl <= BUBBLE;
                    id_inst <= NOP_INST;
                    id_rs1  <= 5'd0;
                    id_rs2  <= 5'd0;
                    id_rd   <= 5'd0;
                end
                LD_DECODE: begin
                    id_ctrl <= dec_ctrl;
                    id_pc   <= if_pc;
                    id_inst <= if_inst;
                    id_rs1  <= rs1;
                    id_rs2  <= rs2;
                    id_rd   <= rd;
                end
                default: ;
            endcase
        end
    end

endmodule
